// File: rtl/pdm_clk_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_clk_gen_if
//  Purpose  : Control and strobe bundle between the PDM clock generator and
//             its controller / downstream consumers.
//  Revision : 1.0  initial release
// ============================================================================
interface pdm_clk_gen_if #(
  parameter int CNT_W = 8
);
  logic             en_clk;
  logic [CNT_W-1:0] half_period;
  logic             load;
  logic             mic_clk;
  logic             running;
  logic             rise_stb;
  logic             fall_stb;
  logic             sample_l_stb;
  logic             sample_r_stb;
  logic             frame_stb;

  // Controller side: requests the clock and programs the divisor.
  modport master (
    output en_clk, half_period, load,
    input  mic_clk, running, rise_stb, fall_stb,
    input  sample_l_stb, sample_r_stb, frame_stb
  );

  // Generator side.
  modport slave (
    input  en_clk, half_period, load,
    output mic_clk, running, rise_stb, fall_stb,
    output sample_l_stb, sample_r_stb, frame_stb
  );
endinterface
`default_nettype wire

// File: rtl/pdm_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_clk_gen
//  Purpose  : PDM microphone clock generator with programmable half-period,
//             glitch-free start/stop, edge, L/R sample and frame strobes.
//  Revision : 1.0  initial release
// ============================================================================
module pdm_clk_gen #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 50,
  parameter int SAMPLE_DLY   = 2,
  parameter int FRAME_LEN    = 64,
  parameter int FRM_W        = 7
) (
  input  wire logic       clk,
  input  wire logic       reset,
  pdm_clk_gen_if.slave    bus
);

  localparam logic [1:0]       c_ST_IDLE  = 2'd0;
  localparam logic [1:0]       c_ST_RUN   = 2'd1;
  localparam logic [1:0]       c_ST_STOP  = 2'd2;

  localparam logic [CNT_W-1:0] c_MIN_HP   = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_RST_HP   = (DEFAULT_HALF < 2) ? c_MIN_HP : CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] c_SMP_OFS  = CNT_W'(SAMPLE_DLY + 1);
  localparam logic [FRM_W-1:0] c_FRM_LAST = FRM_W'(FRAME_LEN - 1);

  // State and datapath registers
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_mic;
  logic             r_running;
  logic [CNT_W-1:0] r_hp;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_v;
  logic [FRM_W-1:0] r_frm;
  logic             r_seen_rise;
  logic             r_rise;
  logic             r_fall;
  logic             r_smp_l;
  logic             r_smp_r;
  logic             r_frame;

  // Combinational next values
  logic [1:0]       w_state_nxt;
  logic             w_active;
  logic             w_halt;
  logic             w_toggle;
  logic             w_rise;
  logic             w_fall;
  logic             w_go_idle;
  logic             w_apply;
  logic [CNT_W-1:0] w_ld_val;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_mic_nxt;
  logic [CNT_W-1:0] w_hp_nxt;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             w_pend_v_nxt;
  logic [FRM_W-1:0] w_frm_nxt;
  logic             w_seen_nxt;
  logic [CNT_W-1:0] w_smp_pt;
  logic             w_run_nxt;

  // Counting is live in RUN/STOPPING; a stop request during the low phase
  // halts immediately, so no toggle is allowed in that cycle.
  assign w_active = (r_state == c_ST_RUN) || (r_state == c_ST_STOP);
  assign w_halt   = (r_state == c_ST_RUN) && !bus.en_clk && !r_mic;
  assign w_toggle = w_active && (r_count == r_hp) && !w_halt;
  assign w_rise   = w_toggle && !r_mic;
  assign w_fall   = w_toggle && r_mic;
  assign w_ld_val = (bus.half_period < c_MIN_HP) ? c_MIN_HP : bus.half_period;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: a high phase is always completed before parking
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.en_clk) w_state_nxt = c_ST_RUN;
      end
      c_ST_RUN: begin
        if (!bus.en_clk) begin
          if (!r_mic || w_fall) w_state_nxt = c_ST_IDLE;
          else                  w_state_nxt = c_ST_STOP;
        end
      end
      c_ST_STOP: begin
        if (bus.en_clk)  w_state_nxt = c_ST_RUN;
        else if (w_fall) w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output/datapath next values, computed so every output can be registered
  always_comb begin
    w_go_idle = (w_state_nxt == c_ST_IDLE);
    w_run_nxt = !w_go_idle;

    w_count_nxt = r_count + c_ONE;
    if (w_go_idle || !w_active || w_toggle) w_count_nxt = c_ONE;

    w_mic_nxt = w_go_idle ? 1'b0 : (r_mic ^ w_toggle);

    // Divisor changes only at a full-period boundary or while parked, so a
    // period never mixes two half-period values.
    w_apply      = r_pend_v && (w_fall || (r_state == c_ST_IDLE));
    w_hp_nxt     = w_apply ? r_pend : r_hp;
    w_pend_nxt   = bus.load ? w_ld_val : r_pend;
    w_pend_v_nxt = bus.load || (r_pend_v && !w_apply);

    w_seen_nxt = w_go_idle ? 1'b0 : (r_seen_rise || w_rise);

    w_frm_nxt = r_frm;
    if (w_go_idle)  w_frm_nxt = '0;
    else if (w_rise) w_frm_nxt = (r_frm == c_FRM_LAST) ? '0 : r_frm + FRM_W'(1);

    w_smp_pt = (c_SMP_OFS < w_hp_nxt) ? c_SMP_OFS : w_hp_nxt;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= c_ONE;
      r_mic       <= 1'b0;
      r_running   <= 1'b0;
      r_hp        <= c_RST_HP;
      r_pend      <= c_RST_HP;
      r_pend_v    <= 1'b0;
      r_frm       <= '0;
      r_seen_rise <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_smp_l     <= 1'b0;
      r_smp_r     <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_mic       <= w_mic_nxt;
      r_running   <= w_run_nxt;
      r_hp        <= w_hp_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_v    <= w_pend_v_nxt;
      r_frm       <= w_frm_nxt;
      r_seen_rise <= w_seen_nxt;
      r_rise      <= w_rise;
      r_fall      <= w_fall;
      r_smp_l     <= w_run_nxt && w_mic_nxt && (w_count_nxt == w_smp_pt);
      r_smp_r     <= w_run_nxt && !w_mic_nxt && (w_count_nxt == w_smp_pt) && w_seen_nxt;
      r_frame     <= w_rise && (r_frm == c_FRM_LAST);
    end
  end

  assign bus.mic_clk      = r_mic;
  assign bus.running      = r_running;
  assign bus.rise_stb     = r_rise;
  assign bus.fall_stb     = r_fall;
  assign bus.sample_l_stb = r_smp_l;
  assign bus.sample_r_stb = r_smp_r;
  assign bus.frame_stb    = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_pdm_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pdm_clk_gen
//  Purpose  : Scoreboard bench for pdm_clk_gen. A time-stamp model predicts
//             every output change/strobe; a monitor matches DUT output events.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pdm_clk_gen;
  localparam int P_CNT_W = 8;
  localparam int P_DEF   = 50;
  localparam int P_SDLY  = 2;
  localparam int P_FLEN  = 4;
  localparam int P_FRM_W = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pdm_clk_gen_if #(.CNT_W(P_CNT_W)) bus ();

  pdm_clk_gen #(
    .CNT_W(P_CNT_W), .DEFAULT_HALF(P_DEF), .SAMPLE_DLY(P_SDLY),
    .FRAME_LEN(P_FLEN), .FRM_W(P_FRM_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // event = {mic_clk, running, rise, fall, sample_l, sample_r, frame}
  typedef struct packed {
    int         cyc;
    logic [6:0] vec;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  // ---------------- reference model (phase start time + edge times) --------
  bit         m_act = 0;
  bit         m_lvl = 0;
  int         m_tph = 0;      // cycle at which the current phase began
  int         m_hp = P_DEF;
  int         m_pend = P_DEF;
  bit         m_pv = 0;
  int         m_rises = 0;    // rises since the clock was last started
  int         m_k = 0;        // output cycle index
  logic [6:0] m_prev = '0;

  task automatic model_step(input bit rst_i, input bit en, input bit ld, input int hv);
    bit rise, fall, fr, sl, sr;
    int s, c;
    ev_t e;
    m_k++;
    rise = 0; fall = 0; fr = 0; sl = 0; sr = 0;
    if (rst_i) begin
      m_act = 0; m_lvl = 0; m_tph = 0; m_hp = P_DEF; m_pv = 0; m_rises = 0;
      e.cyc = m_k; e.vec = '0;
      q.push_back(e);
      m_prev = '0;
      return;
    end
    if (!m_act) begin
      if (m_pv) begin m_hp = m_pend; m_pv = 0; end
      if (en) begin m_act = 1; m_lvl = 0; m_tph = m_k; m_rises = 0; end
    end else if (!en && !m_lvl) begin
      m_act = 0; m_rises = 0;
    end else if (m_k == m_tph + m_hp) begin
      m_lvl = !m_lvl;
      m_tph = m_k;
      if (m_lvl) begin
        rise = 1;
        m_rises++;
        fr = (m_rises % P_FLEN) == 0;
      end else begin
        fall = 1;
        if (m_pv) begin m_hp = m_pend; m_pv = 0; end
        if (!en) begin m_act = 0; m_rises = 0; end
      end
    end
    if (ld) begin m_pend = (hv < 2) ? 2 : hv; m_pv = 1; end
    if (m_act) begin
      s  = (P_SDLY + 1 < m_hp) ? P_SDLY + 1 : m_hp;
      c  = m_k - m_tph + 1;
      sl = m_lvl && (c == s);
      sr = !m_lvl && (c == s) && (m_rises > 0);
    end
    e.cyc = m_k;
    e.vec = {m_lvl, m_act, rise, fall, sl, sr, fr};
    if (e.vec != m_prev || e.vec[4:0] != 5'd0) q.push_back(e);
    m_prev = e.vec;
  endtask

  // ---------------- monitor ----------------
  logic       rst_q = 1'b0;
  logic [6:0] d_prev = '0;
  logic [6:0] mon_v;
  ev_t        mon_e;
  int         mon_k = 0;

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    mon_k++;
    mon_v = {bus.mic_clk, bus.running, bus.rise_stb, bus.fall_stb,
             bus.sample_l_stb, bus.sample_r_stb, bus.frame_stb};
    if (rst_q || mon_v != d_prev || mon_v[4:0] != 5'd0) begin
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event: got cycle=%0d out=%b, expected no event", mon_k, mon_v);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != mon_k || mon_e.vec !== mon_v) begin
          n_errors++;
          $display("FAIL event: got cycle=%0d out=%b, expected cycle=%0d out=%b",
                   mon_k, mon_v, mon_e.cyc, mon_e.vec);
        end
      end
    end
    d_prev = mon_v;
  end

  // ---------------- stimulus ----------------
  bit en_s = 0;

  task automatic cyc(input bit r, input bit en, input bit ld, input int hv);
    reset           = r;
    bus.en_clk      = en;
    bus.load        = ld;
    bus.half_period = P_CNT_W'(hv);
    @(posedge clk);
    model_step(r, en, ld, hv);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, en_s, 0, 0);
  endtask

  task automatic ld(input int v);
    cyc(0, en_s, 1, v);
  endtask

  // advance until the model sits at position pos of a phase at level lvl
  task automatic wait_pos(input bit lvl, input int pos, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_act && m_lvl == lvl && (m_k - m_tph + 1) == pos) return;
      cyc(0, en_s, 0, 0);
    end
  endtask

  initial begin
    int r;
    reset = 1'b1; bus.en_clk = 1'b0; bus.load = 1'b0; bus.half_period = '0;
    repeat (3) cyc(1, 0, 0, 0);

    // defaults: first rise 50 cycles after start, period 100
    en_s = 1; run(260);

    // reload mid high phase, then clamp
    wait_pos(1, 7, 200); ld(10); run(140);
    ld(1); run(60);
    ld(50); run(30);

    // stop during high phase, then during low phase
    wait_pos(1, 6, 300); en_s = 0; run(60);
    en_s = 1; run(120);
    wait_pos(0, 10, 200); en_s = 0; run(5);

    // frame strobes at hp=3, stop/restart resets frame count
    ld(3); run(3);
    en_s = 1; run(80);
    wait_pos(1, 2, 20); en_s = 0; run(6);
    en_s = 1; run(60);

    // reset with a pending load discards it
    ld(9); cyc(1, en_s, 0, 0); run(120);

    // stop request withdrawn inside the draining high phase
    wait_pos(1, 5, 200); en_s = 0; run(10); en_s = 1; run(150);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      en_s = !en_s;
      else if (r <= 6) ld($urandom_range(0, 12));
      else if (r == 7) cyc(1, en_s, 0, 0);
      run($urandom_range(1, 40));
    end

    en_s = 0; run(120);
    @(negedge clk); #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_events: got %0d unmatched, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
